// File: rtl/insn_fetch_unit.sv
// Fetch controller for a 1-cycle registered-read instruction memory; first word visible 3 cycles after start/redirect, then one per cycle.
// Words land in a 2-entry queue; issue is credit-limited so out_ready low stalls fetch without loss.
module insn_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] start_pc,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_din,
  output logic        load_ready,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_insn,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_din,
  output logic        imem_we,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [31:0] out_pc,
  output logic        running
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] f_pc;
  logic [31:0] infl_pc;
  logic        infl;
  logic [1:0]  occ;
  logic [31:0] q0_insn, q0_pc, q1_insn, q1_pc;

  logic run, pop, push, flush, issue;

  assign run   = (state == RUN);
  assign pop   = out_valid & out_ready;
  assign flush = run & (halt | redirect);
  assign push  = infl & ~flush;
  // Queue slots plus the outstanding read must never exceed the 2 entries.
  assign issue = run & ~flush &
                 (({1'b0, occ} + {2'b00, infl}) < (3'd2 + {2'b00, pop}));

  assign imem_pc   = f_pc;
  assign imem_addr = load_addr;
  assign imem_din  = load_din;
  assign out_valid = (occ != 2'd0);
  assign out_insn  = q0_insn;
  assign out_pc    = q0_pc;

  always_comb begin
    state_nxt  = state;
    running    = 1'b0;
    load_ready = 1'b0;
    imem_we    = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        imem_we    = load_we;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        running = 1'b1;
        if (halt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      f_pc    <= RESET_PC;
      infl    <= 1'b0;
      infl_pc <= 32'h0;
      occ     <= 2'd0;
      q0_insn <= 32'h0;
      q0_pc   <= 32'h0;
      q1_insn <= 32'h0;
      q1_pc   <= 32'h0;
    end else begin
      state <= state_nxt;

      if (!run) begin
        infl <= 1'b0;
        if (start) f_pc <= start_pc;
      end else if (halt) begin
        infl <= 1'b0;
      end else if (redirect) begin
        infl <= 1'b0;
        f_pc <= redirect_pc;
      end else begin
        infl <= issue;
        if (issue) begin
          infl_pc <= f_pc;
          f_pc    <= f_pc + 32'd4;
        end
      end

      // On flush the head slot keeps the last presented word so the empty output stays defined.
      if (flush) begin
        occ <= 2'd0;
      end else begin
        occ <= occ + {1'b0, push} - {1'b0, pop};
        if (pop && occ == 2'd2) begin
          q0_insn <= q1_insn;
          q0_pc   <= q1_pc;
          if (push) begin
            q1_insn <= imem_insn;
            q1_pc   <= infl_pc;
          end
        end else if (pop) begin
          if (push) begin
            q0_insn <= imem_insn;
            q0_pc   <= infl_pc;
          end
        end else if (push) begin
          if (occ == 2'd0) begin
            q0_insn <= imem_insn;
            q0_pc   <= infl_pc;
          end else begin
            q1_insn <= imem_insn;
            q1_pc   <= infl_pc;
          end
        end
      end
    end
  end

endmodule
